// File: rtl/phy_tx_scheduler.sv
// phy_tx_scheduler: sequences the PHY transmit word stream in the clk_2f
// domain. After reset or link loss it sends a comma preamble, then arbitrates
// two word sources round-robin in bounded bursts; idle slots carry IDLE_WORD.
// Optional per-requester word counters are built when TX_STATS_EN is defined.
module phy_tx_scheduler #(
    parameter int unsigned SYNC_WORDS = 4,
    parameter int unsigned MAX_BURST  = 4,
    parameter logic [31:0] IDLE_WORD  = 32'hBCBCBCBC
) (
    input  logic        clk_2f,
    input  logic        reset,
    input  logic        link_en,
    input  logic        req0,
    input  logic [31:0] data0,
    output logic        gnt0,
    input  logic        req1,
    input  logic [31:0] data1,
    output logic        gnt1,
    output logic [31:0] data_input,
    output logic        valid,
    output logic        active,
`ifdef TX_STATS_EN
    output logic [15:0] cnt0,
    output logic [15:0] cnt1,
`endif
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        S_SYNC   = 2'd0,
        S_IDLE   = 2'd1,
        S_GRANT0 = 2'd2,
        S_GRANT1 = 2'd3
    } state_t;

    localparam int unsigned       SYNC_W     = (SYNC_WORDS > 1) ? $clog2(SYNC_WORDS) : 1;
    localparam logic [SYNC_W-1:0] SYNC_LAST  = SYNC_W'(SYNC_WORDS - 1);
    localparam logic [3:0]        BURST_LAST = 4'(MAX_BURST - 1);

    state_t            state_q, state_d;
    logic [SYNC_W-1:0] sync_cnt_q, sync_cnt_d;
    logic [3:0]        burst_cnt_q, burst_cnt_d;
    logic              last_q, last_d;
    logic              active_q, active_d;
    logic              valid_q;
    logic [31:0]       data_q, data_d;
    logic              xfer;

    // Moore grants, gated by link_en so a link drop stops transfers at once
    assign gnt0 = (state_q == S_GRANT0) & link_en;
    assign gnt1 = (state_q == S_GRANT1) & link_en;
    assign xfer = (gnt0 & req0) | (gnt1 & req1);

    assign data_input = data_q;
    assign valid      = valid_q;
    assign active     = active_q;
    assign state      = state_q;

    // State and control registers
    always_ff @(posedge clk_2f or posedge reset) begin
        if (reset) begin
            state_q     <= S_SYNC;
            sync_cnt_q  <= '0;
            burst_cnt_q <= '0;
            last_q      <= 1'b1;
            active_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_cnt_q  <= sync_cnt_d;
            burst_cnt_q <= burst_cnt_d;
            last_q      <= last_d;
            active_q    <= active_d;
        end
    end

    // Next-state: preamble count, round-robin selection and burst limiting
    always_comb begin
        state_d     = state_q;
        sync_cnt_d  = sync_cnt_q;
        burst_cnt_d = burst_cnt_q;
        last_d      = last_q;
        active_d    = active_q;
        if (!link_en) begin
            state_d     = S_SYNC;
            active_d    = 1'b0;
            sync_cnt_d  = '0;
            burst_cnt_d = '0;
        end else begin
            case (state_q)
                S_SYNC: begin
                    active_d = 1'b0;
                    if (sync_cnt_q == SYNC_LAST) begin
                        state_d    = S_IDLE;
                        active_d   = 1'b1;
                        sync_cnt_d = '0;
                    end else begin
                        sync_cnt_d = sync_cnt_q + SYNC_W'(1);
                    end
                end
                S_IDLE: begin
                    active_d = 1'b1;
                    if (req0 || req1) begin
                        burst_cnt_d = '0;
                        // The requester that did not go last wins a tie
                        if (last_q) state_d = req0 ? S_GRANT0 : S_GRANT1;
                        else        state_d = req1 ? S_GRANT1 : S_GRANT0;
                    end
                end
                S_GRANT0: begin
                    if (req0) begin
                        burst_cnt_d = burst_cnt_q + 4'd1;
                        if (burst_cnt_q == BURST_LAST) begin
                            last_d      = 1'b0;
                            burst_cnt_d = '0;
                            // req0 is high here, so without req1 a fresh burst follows
                            state_d     = req1 ? S_GRANT1 : S_GRANT0;
                        end
                    end else begin
                        last_d      = 1'b0;
                        burst_cnt_d = '0;
                        state_d     = S_IDLE;
                    end
                end
                S_GRANT1: begin
                    if (req1) begin
                        burst_cnt_d = burst_cnt_q + 4'd1;
                        if (burst_cnt_q == BURST_LAST) begin
                            last_d      = 1'b1;
                            burst_cnt_d = '0;
                            state_d     = req0 ? S_GRANT0 : S_GRANT1;
                        end
                    end else begin
                        last_d      = 1'b1;
                        burst_cnt_d = '0;
                        state_d     = S_IDLE;
                    end
                end
                default: state_d = S_SYNC;
            endcase
        end
    end

    // Output word mux: granted requester data on a transfer, comma otherwise
    always_comb begin
        data_d = IDLE_WORD;
        if (xfer) data_d = gnt0 ? data0 : data1;
    end

    // Registered PHY word and valid, one cycle after acceptance
    always_ff @(posedge clk_2f or posedge reset) begin
        if (reset) begin
            data_q  <= IDLE_WORD;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= xfer;
        end
    end

`ifdef TX_STATS_EN
    logic [15:0] cnt0_q, cnt1_q;

    assign cnt0 = cnt0_q;
    assign cnt1 = cnt1_q;

    // Per-requester transferred-word counters, wrap naturally, reset only
    always_ff @(posedge clk_2f or posedge reset) begin
        if (reset) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (gnt0 && req0) cnt0_q <= cnt0_q + 16'd1;
            if (gnt1 && req1) cnt1_q <= cnt1_q + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_phy_tx_scheduler.sv
// Directed, table-driven bench for phy_tx_scheduler. Each row is applied
// after a negedge; outputs are checked 1 ns later, before the next posedge.
module tb_phy_tx_scheduler;

    localparam logic [31:0] BC = 32'hBCBCBCBC;

    logic        clk_2f = 1'b0;
    logic        reset;
    logic        link_en;
    logic        req0, req1;
    logic [31:0] data0, data1;
    logic        gnt0, gnt1;
    logic [31:0] data_input;
    logic        valid, active;
    logic [1:0]  state;
`ifdef TX_STATS_EN
    logic [15:0] cnt0, cnt1;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk_2f = ~clk_2f;

    phy_tx_scheduler #(
        .SYNC_WORDS(4),
        .MAX_BURST (4),
        .IDLE_WORD (32'hBCBCBCBC)
    ) dut (
        .clk_2f    (clk_2f),
        .reset     (reset),
        .link_en   (link_en),
        .req0      (req0),
        .data0     (data0),
        .gnt0      (gnt0),
        .req1      (req1),
        .data1     (data1),
        .gnt1      (gnt1),
        .data_input(data_input),
        .valid     (valid),
        .active    (active),
`ifdef TX_STATS_EN
        .cnt0      (cnt0),
        .cnt1      (cnt1),
`endif
        .state     (state)
    );

    typedef struct {
        logic        le, r0, r1;
        logic [31:0] d0, d1;
        logic        g0, g1, v, a;
        logic [31:0] dat;
        logic [1:0]  st;
    } vec_t;

    localparam int NV = 43;
    vec_t tbl [NV];

    function automatic vec_t mk(input logic le, input logic r0, input logic r1,
                                input logic [31:0] d0, input logic [31:0] d1,
                                input logic g0, input logic g1, input logic v,
                                input logic a, input logic [31:0] dat,
                                input logic [1:0] st);
        vec_t t;
        t.le = le; t.r0 = r0; t.r1 = r1; t.d0 = d0; t.d1 = d1;
        t.g0 = g0; t.g1 = g1; t.v = v; t.a = a; t.dat = dat; t.st = st;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic g0, input logic g1,
                            input logic v, input logic a, input logic [31:0] dat,
                            input logic [1:0] st);
        chk({tag, " gnt0"},       32'(gnt0),   32'(g0));
        chk({tag, " gnt1"},       32'(gnt1),   32'(g1));
        chk({tag, " valid"},      32'(valid),  32'(v));
        chk({tag, " active"},     32'(active), 32'(a));
        chk({tag, " data_input"}, data_input,  dat);
        chk({tag, " state"},      32'(state),  32'(st));
    endtask

    initial begin
        // SYNC preamble, no requests
        for (int i = 0; i < 4; i++)
            tbl[i] = mk(1,0,0, 0,0, 0,0,0,0, BC, 0);
        // req0 alone for 6 words: fresh burst with no gap at word 4
        tbl[4]  = mk(1,1,0, 32'hADFEBA01,0, 0,0,0,1, BC, 1);
        tbl[5]  = mk(1,1,0, 32'hADFEBA01,0, 1,0,0,1, BC, 2);
        tbl[6]  = mk(1,1,0, 32'hFAFAFA01,0, 1,0,1,1, 32'hADFEBA01, 2);
        tbl[7]  = mk(1,1,0, 32'hAAAA1234,0, 1,0,1,1, 32'hFAFAFA01, 2);
        tbl[8]  = mk(1,1,0, 32'h12345678,0, 1,0,1,1, 32'hAAAA1234, 2);
        tbl[9]  = mk(1,1,0, 32'hBBBBAAAA,0, 1,0,1,1, 32'h12345678, 2);
        tbl[10] = mk(1,1,0, 32'hFFFFEEEE,0, 1,0,1,1, 32'hBBBBAAAA, 2);
        tbl[11] = mk(1,0,0, 0,0,             1,0,1,1, 32'hFFFFEEEE, 2);
        // Both requesting: last=0 so requester 1 wins, then 4-word alternation
        tbl[12] = mk(1,1,1, 32'h1000000C,32'h2000000C, 0,0,0,1, BC, 1);
        tbl[13] = mk(1,1,1, 32'h1000000D,32'h2000000D, 0,1,0,1, BC, 3);
        tbl[14] = mk(1,1,1, 32'h1000000E,32'h2000000E, 0,1,1,1, 32'h2000000D, 3);
        tbl[15] = mk(1,1,1, 32'h1000000F,32'h2000000F, 0,1,1,1, 32'h2000000E, 3);
        tbl[16] = mk(1,1,1, 32'h10000010,32'h20000010, 0,1,1,1, 32'h2000000F, 3);
        tbl[17] = mk(1,1,1, 32'h10000011,32'h20000011, 1,0,1,1, 32'h20000010, 2);
        tbl[18] = mk(1,1,1, 32'h10000012,32'h20000012, 1,0,1,1, 32'h10000011, 2);
        tbl[19] = mk(1,1,1, 32'h10000013,32'h20000013, 1,0,1,1, 32'h10000012, 2);
        tbl[20] = mk(1,1,1, 32'h10000014,32'h20000014, 1,0,1,1, 32'h10000013, 2);
        tbl[21] = mk(1,1,1, 32'h10000015,32'h20000015, 0,1,1,1, 32'h10000014, 3);
        tbl[22] = mk(1,1,1, 32'h10000016,32'h20000016, 0,1,1,1, 32'h20000015, 3);
        tbl[23] = mk(1,0,0, 0,0,                       0,1,1,1, 32'h20000016, 3);
        // Early release by req0 after 2 words; req1 arrives during release
        tbl[24] = mk(1,1,0, 32'h30000018,0, 0,0,0,1, BC, 1);
        tbl[25] = mk(1,1,0, 32'h30000019,0, 1,0,0,1, BC, 2);
        tbl[26] = mk(1,1,0, 32'h3000001A,0, 1,0,1,1, 32'h30000019, 2);
        tbl[27] = mk(1,0,1, 0,32'h4000001B, 1,0,1,1, 32'h3000001A, 2);
        tbl[28] = mk(1,0,1, 0,32'h4000001C, 0,0,0,1, BC, 1);
        tbl[29] = mk(1,0,1, 0,32'h4000001D, 0,1,0,1, BC, 3);
        tbl[30] = mk(1,0,0, 0,0,            0,1,1,1, 32'h4000001D, 3);
        // Link loss at word 3 of a burst, resync, then word 3 goes out
        tbl[31] = mk(1,1,0, 32'h5000001F,0, 0,0,0,1, BC, 1);
        tbl[32] = mk(1,1,0, 32'h50000020,0, 1,0,0,1, BC, 2);
        tbl[33] = mk(1,1,0, 32'h50000021,0, 1,0,1,1, 32'h50000020, 2);
        tbl[34] = mk(0,1,0, 32'h50000022,0, 0,0,1,1, 32'h50000021, 2);
        for (int i = 35; i < 39; i++)
            tbl[i] = mk(1,1,0, 32'h50000022,0, 0,0,0,0, BC, 0);
        tbl[39] = mk(1,1,0, 32'h50000022,0, 0,0,0,1, BC, 1);
        tbl[40] = mk(1,1,0, 32'h50000022,0, 1,0,0,1, BC, 2);
        tbl[41] = mk(1,0,0, 0,0,             1,0,1,1, 32'h50000022, 2);
        tbl[42] = mk(1,0,0, 0,0,             0,0,0,1, BC, 1);

        reset = 1'b1; link_en = 1'b0;
        req0 = 1'b0; req1 = 1'b0; data0 = '0; data1 = '0;
        repeat (2) @(negedge clk_2f);
        #1;
        chk_outs("reset", 0, 0, 0, 0, BC, 0);
`ifdef TX_STATS_EN
        chk("reset cnt0", 32'(cnt0), 32'd0);
        chk("reset cnt1", 32'(cnt1), 32'd0);
`endif
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            link_en = tbl[i].le; req0 = tbl[i].r0; req1 = tbl[i].r1;
            data0 = tbl[i].d0; data1 = tbl[i].d1;
            #1;
            chk_outs($sformatf("row%0d", i), tbl[i].g0, tbl[i].g1, tbl[i].v,
                     tbl[i].a, tbl[i].dat, tbl[i].st);
            @(posedge clk_2f);
            @(negedge clk_2f);
        end

`ifdef TX_STATS_EN
        chk("stats cnt0", 32'(cnt0), 32'd15);
        chk("stats cnt1", 32'(cnt1), 32'd7);
`endif

        // Async reset pulse between edges in the middle of a burst
        req0 = 1'b1; data0 = 32'h60000000;
        @(posedge clk_2f); @(negedge clk_2f);
        #1;
        chk_outs("pre-reset grant", 1, 0, 0, 1, BC, 2);
        @(posedge clk_2f); @(negedge clk_2f);
        data0 = 32'h60000001;
        #1;
        chk_outs("pre-reset word", 1, 0, 1, 1, 32'h60000000, 2);
        @(posedge clk_2f);
        #2;
        reset = 1'b1;
        #1;
        chk_outs("async reset", 0, 0, 0, 0, BC, 0);
`ifdef TX_STATS_EN
        chk("async reset cnt0", 32'(cnt0), 32'd0);
        chk("async reset cnt1", 32'(cnt1), 32'd0);
`endif
        @(negedge clk_2f);
        reset = 1'b0;
        @(posedge clk_2f); @(negedge clk_2f);
        #1;
        chk_outs("post-reset sync", 0, 0, 0, 0, BC, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
